// File: rtl/bf_input_commutator.sv
// Input commutator for a radix-2 DIF FFT stage: buffers the first half of each
// frame, then pairs every second-half sample with its stored partner plus twiddle.

package bf_input_commutator_pkg;
  parameter int DATA_W = 16;

  typedef logic [DATA_W-1:0] data_sample_t;

  typedef struct packed {
    logic         valid;
    data_sample_t data;
  } data_bus_t;
endpackage

module bf_input_commutator
  import bf_input_commutator_pkg::*;
#(
  parameter int HALF  = 8,
  parameter int TW_AW = $clog2(HALF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  data_bus_t        in_sample,
  input  data_sample_t     tw_data,
  output logic [TW_AW-1:0] tw_addr,
  output data_bus_t        add_up,
  output data_bus_t        add_down,
  output data_bus_t        sub_up,
  output data_bus_t        sub_down,
  output data_bus_t        twiddle,
  output logic             frame_done
);

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_t;

  state_t           state;
  logic [TW_AW-1:0] cnt;
  data_sample_t     buffer [HALF];

  logic             cnt_last;
  logic             buf_wr;
  logic [TW_AW-1:0] buf_wr_idx;
  data_sample_t     buf_rd;

  assign cnt_last   = (cnt == TW_AW'(HALF - 1));
  // A flush forces the concurrent sample into slot 0 of a fresh frame.
  assign buf_wr     = in_sample.valid && (flush || state == FILL);
  assign buf_wr_idx = flush ? '0 : cnt;
  assign buf_rd     = buffer[cnt];

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (buf_wr) begin
      buffer[buf_wr_idx] <= in_sample.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      cnt        <= '0;
      tw_addr    <= '0;
      add_up     <= '0;
      add_down   <= '0;
      sub_up     <= '0;
      sub_down   <= '0;
      twiddle    <= '0;
      frame_done <= 1'b0;
    end else begin
      add_up     <= '0;
      add_down   <= '0;
      sub_up     <= '0;
      sub_down   <= '0;
      frame_done <= 1'b0;
      // Twiddle trails the operands by one cycle: tw_addr was loaded with the pair.
      if (add_up.valid) begin
        twiddle <= '{valid: 1'b1, data: tw_data};
      end else begin
        twiddle <= '0;
      end

      if (flush) begin
        state   <= FILL;
        cnt     <= in_sample.valid ? TW_AW'(1) : '0;
        twiddle <= '0;
      end else if (in_sample.valid) begin
        cnt <= cnt + TW_AW'(1);
        case (state)
          FILL: begin
            if (cnt_last) begin
              state <= PAIR;
            end
          end
          PAIR: begin
            add_up     <= '{valid: 1'b1, data: buf_rd};
            sub_up     <= '{valid: 1'b1, data: buf_rd};
            add_down   <= '{valid: 1'b1, data: in_sample.data};
            sub_down   <= '{valid: 1'b1, data: in_sample.data};
            tw_addr    <= cnt;
            frame_done <= cnt_last;
            if (cnt_last) begin
              state <= FILL;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule
